// File: rtl/avalon_test_master_if.sv
// ---------------------------------------------------------------------------
// avalon_test_master_if
// Bundles the command, write-data, read-data and Avalon-MM bus signals of
// avalon_test_master. The clock and reset stay plain ports on the module.
//
//   master modport : the view used by avalon_test_master itself
//   slave  modport : the view used by whatever drives commands and models
//                    the Avalon slave (testbench or surrounding logic)
//
// Signals
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command handshake
//   wdata_valid/wdata/wdata_ready                  : write-word stream in
//   rdata_valid/rdata                              : read-word stream out
//   busy                                           : burst in progress
//   address/read/write/writedata/readdata/waitrequest : Avalon-MM master bus
// ---------------------------------------------------------------------------
interface avalon_test_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;

  logic                  wdata_valid;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_ready;

  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  busy;

  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    input  readdata, waitrequest,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy,
    output address, read, write, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    output readdata, waitrequest,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy,
    input  address, read, write, writedata
  );

endinterface

// File: rtl/avalon_test_master.sv
// ---------------------------------------------------------------------------
// avalon_test_master
// Turns a single burst command (start address, length-1, direction) into a
// sequence of Avalon-MM word accesses on an incrementing, wrapping address.
// Write words are streamed in through a valid/ready pair; read words come
// back on rdata/rdata_valid a fixed READ_LATENCY cycles after each accepted
// read, without backpressure.
//
// Parameters
//   ADDR_WIDTH   : word address width (also width of cmd_addr / cmd_len)
//   DATA_WIDTH   : data word width
//   READ_LATENCY : fixed slave read latency in cycles, 1..4
//
// Ports
//   avalon_clock : sole clock, rising edge
//   resetn       : asynchronous active-low reset
//   av           : avalon_test_master_if.master -- command, write stream,
//                  read stream, busy and the Avalon-MM master signals
// ---------------------------------------------------------------------------
module avalon_test_master #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 avalon_clock,
  input  logic                 resetn,
  avalon_test_master_if.master av
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
  // Bit i set = a read accepted i+1 cycles ago; the top bit is the word
  // arriving on readdata in the current cycle.
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

  logic wr_beat;
  logic rd_beat;

  // A write beat needs both a word and a non-stalled slave; a read beat only
  // needs the slave to stop stalling, since read is held high throughout RD.
  assign wr_beat = (state_q == WR) && av.wdata_valid && !av.waitrequest;
  assign rd_beat = (state_q == RD) && !av.waitrequest;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;

    rd_pipe_d[0] = rd_beat;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    unique case (state_q)
      IDLE: begin
        if (av.cmd_valid) begin
          addr_d   = av.cmd_addr;
          remain_d = av.cmd_len;
          state_d  = av.cmd_write ? WR : RD;
        end
      end

      WR, RD: begin
        if (wr_beat || rd_beat) begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          addr_d = addr_q + 1'b1;
          if (remain_q == '0) begin
            // Reads still in flight are collected in DRAIN.
            state_d = (state_q == WR) ? IDLE : DRAIN;
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end
      end

      DRAIN: begin
        // Leave only once the pipe has been seen empty, so the last
        // rdata_valid pulse is emitted while busy is still high.
        if (rd_pipe_q == '0) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: the read-tracking pipe is reset along with the FSM: an aborted
  // burst must not leave stale valid bits that would emit rdata_valid later.
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  // Outputs decode the registered state; the write path passes the stream
  // straight through in WR so a word and its strobe appear in the same cycle.
  assign av.cmd_ready   = (state_q == IDLE);
  assign av.busy        = (state_q != IDLE);
  assign av.address     = addr_q;
  assign av.read        = (state_q == RD);
  assign av.write       = (state_q == WR) && av.wdata_valid;
  assign av.writedata   = (state_q == WR) ? av.wdata : '0;
  assign av.wdata_ready = (state_q == WR) && !av.waitrequest;
  assign av.rdata_valid = rd_pipe_q[READ_LATENCY-1];
  assign av.rdata       = rd_pipe_q[READ_LATENCY-1] ? av.readdata : '0;

endmodule

// File: doc/avalon_test_master.md
AVALON_TEST_MASTER -- requirements
Module: avalon_test_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the width of the Avalon word address and of cmd_addr.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of writedata, readdata, wdata and rdata.
REQ-003 Parameter READ_LATENCY, default 1, range 1..4, SHALL be the fixed slave read latency in cycles.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- avalon_clock  in  1  sole clock; all state changes on its rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  ADDR_WIDTH  burst length minus one
- wdata_valid  in  1  write word offered
- wdata  in  DATA_WIDTH  write word
- wdata_ready  out  1  write word consumed when high together with wdata_valid
- rdata_valid  out  1  rdata valid this cycle; no backpressure
- rdata  out  DATA_WIDTH  read word
- busy  out  1  burst in progress
- address  out  ADDR_WIDTH  Avalon address
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- writedata  out  DATA_WIDTH  Avalon write data
- readdata  in  DATA_WIDTH  Avalon read data
- waitrequest  in  1  slave stall

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, WR, RD, DRAIN.
REQ-006 cmd_ready SHALL be 1 only in IDLE; in any other state the command inputs SHALL be ignored.
REQ-007 On a command handshake the block SHALL latch cmd_addr into the address counter and cmd_len into the remaining-words counter, then enter WR if cmd_write is 1, else RD.
REQ-008 In WR, the outputs SHALL be: write = wdata_valid; writedata = wdata; wdata_ready = !waitrequest. read SHALL be 0.
REQ-009 A write beat SHALL complete when write=1 and waitrequest=0; each completed beat SHALL increment address by 1, modulo 2^ADDR_WIDTH.
REQ-010 In WR, a completed beat with remaining-words = 0 SHALL return the FSM to IDLE; otherwise remaining-words SHALL decrement.
REQ-011 In RD, read SHALL be held at 1 every cycle; a read beat SHALL complete when waitrequest=0, with the same address and counter rules as writes.
REQ-012 In RD, the last completed read beat SHALL move the FSM to DRAIN.
REQ-013 Each completed read beat SHALL be tracked in a READ_LATENCY-deep valid shift register.
REQ-014 Exactly READ_LATENCY cycles after a completed read beat, rdata_valid SHALL be 1 and rdata SHALL equal readdata sampled in that cycle.
REQ-015 Back-to-back read beats SHALL yield back-to-back rdata_valid pulses, in issue order.
REQ-016 DRAIN SHALL return to IDLE in the cycle after the shift register becomes empty; DRAIN SHALL assert neither read nor write.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 address SHALL equal the address counter in all states, including IDLE.
REQ-019 A burst that crosses address 2^ADDR_WIDTH-1 SHALL wrap to 0 without error.
REQ-020 cmd_len = 2^ADDR_WIDTH-1 SHALL produce a full-space burst of 2^ADDR_WIDTH beats.
REQ-021 waitrequest held high SHALL stall the block indefinitely, with no beat counted and no strobe dropped.

Reset
REQ-022 While resetn=0, the state SHALL be IDLE and the following outputs SHALL be 0: address, read, write, writedata, rdata, rdata_valid, busy, wdata_ready. cmd_ready SHALL be 1.
REQ-023 Reset asserted mid-burst SHALL abort the burst immediately, discard all outstanding reads, and emit no further rdata_valid.

Verification
REQ-024 Write burst: cmd_addr=3, cmd_len=3, wdata 0xA0..0xA3 continuous, waitrequest=0 -> writes of 0xA0..0xA3 to addresses 3,4,5,6 on 4 consecutive cycles, then IDLE.
REQ-025 Read burst: cmd_addr=30, cmd_len=3, READ_LATENCY=2 -> reads at addresses 30,31,0,1; four rdata_valid pulses starting 2 cycles after the first read; busy falls after the last pulse.
REQ-026 Stalls: waitrequest high for 3 cycles during the second write beat -> write and writedata held stable through the stall; exactly 4 beats total.
REQ-027 Write-data gaps: wdata_valid low for 2 cycles during a write burst -> write=0 during the gap; address does not advance.
REQ-028 Abort: resetn pulsed low during a read burst with 2 reads outstanding -> no rdata_valid after reset; cmd_ready=1 and address=0.
REQ-029 Ignored command: cmd_valid held high while busy -> the second command is accepted only in the cycle after the FSM returns to IDLE.
